axis_in: RTL and testbench
==========================

Name: axis_in

Overview:
AXI4-Stream slave that receives one N-coefficient polynomial per frame and writes it into the multiplier's coefficient memory. It is the input-side counterpart of the output stream interface. Beats arrive in coefficient order 0..N-1. Each beat is written to a banked address {addr_hi, addr_lo} spread across M AU banks. The block flags malformed frames (early or missing tlast) and pulses a done strobe to the multiplier control.

Parameters:
N, 541, coefficients per frame (beats per polynomial)
M, 1, number of AUs/memory banks; addr_lo cycles 0..M-1
D_WIDTH, 16, tdata and write_data width
HI_W, clog2(ceil(N/M)-1), addr_hi width (clog2(x) = bits needed to represent x; clog2(0)=0)
LO_W, clog2(M-1), addr_lo width (0 when M=1)
AW, M==1 ? clog2(N-1) : HI_W+LO_W, write_addr width

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
load  in  1  level; request to receive one frame
din_tdata  in  D_WIDTH  stream data (coefficient)
din_tvalid  in  1  stream valid
din_tlast  in  1  stream last (expected on beat N-1)
din_tready  out  1  stream ready
write_addr  out  AW  memory write address
write_data  out  D_WIDTH  memory write data
write_en  out  1  memory write strobe
write_done  out  1  one-cycle pulse; frame complete
frame_err  out  1  sticky; tlast mismatch in last frame

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high. While reset=1 at a clock edge: state=IDLE, beat counter=0, addr_hi=0, addr_lo=0, and all outputs are 0 (din_tready, write_en, write_addr, write_data, write_done, frame_err). Reset mid-frame abandons the frame with no write_done.
- States: IDLE, RECEIVE, DONE.
- IDLE: din_tready=0. If load=1: clear counter, addr_hi and addr_lo, clear frame_err, then go to RECEIVE.
- RECEIVE: din_tready=1, driven combinationally from state. A handshake is din_tvalid & din_tready. Beats with din_tvalid=0 are ignored, and gaps of any length are allowed.
- On each handshake, registered with 1-cycle latency: write_en=1, write_data=din_tdata, and write_addr = current address.
- Address when M=1: write_addr = counter.
- Address when M>1: write_addr = {addr_hi, addr_lo}. If addr_lo<M-1, addr_lo increments; otherwise addr_lo=0 and addr_hi increments. For M that is not a power of two this leaves address gaps.
- The counter increments on each handshake.
- Frame end: a handshake with counter==N-1 OR din_tlast=1 ends the frame, and the state goes to DONE.
  - counter==N-1 with tlast=0 sets frame_err (missing tlast).
  - tlast=1 with counter<N-1 sets frame_err (short frame). Remaining coefficients are not written.
  - counter==N-1 with tlast=1 is a good frame, and frame_err stays 0.
- Beats after the frame end are not accepted, because din_tready=0.
- write_done=1 for exactly one cycle, in the same cycle as the final write_en (both registered from the ending handshake).
- DONE: din_tready=0 and write_en=0. Stay in DONE while load=1, then go to IDLE when load=0. Exactly one frame is received per load assertion.
- write_en is 0 in every cycle not following a handshake. write_addr and write_data hold their last values when write_en=0.
- load deasserted during RECEIVE has no effect; the frame continues.

Test Plan:
- N=541, M=1, load=1, 541 back-to-back beats with data=i and tlast on beat 540 -> 541 write_en pulses, addr 0..540 with data 0..540; write_done one cycle coincident with addr 540; frame_err=0; din_tready=0 afterwards.
- N=7, M=3 (HI_W=2, LO_W=2), 7 beats -> write_addr sequence 0,1,2,4,5,6,8; write_done on addr 8.
- N=541, M=1, random tvalid gaps (about 50% duty) -> same writes as the first scenario; no write_en during gaps; each write_en exactly 1 cycle after its handshake.
- N=541, tlast on beat 99 -> 100 writes (addr 0..99), write_done pulse, frame_err=1; beat 100 presented but din_tready=0, so not accepted.
- N=541, no tlast on beat 540 -> 541 writes, write_done, frame_err=1. Drop load then reassert and send a good frame -> frame_err clears on entering RECEIVE and ends 0.
- reset=1 for 1 cycle after beat 200 -> all outputs 0 next cycle and no write_done. Reassert load -> new frame starts at addr 0.

Source files
------------

// File: rtl/axis_in.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : axis_in
//  Brief    : AXI4-Stream slave that writes one N-coefficient polynomial per
//             frame into the banked coefficient memory. It flags frames whose
//             tlast is early or missing and pulses write_done when a frame
//             completes.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_in #(
  parameter  int N       = 541,
  parameter  int M       = 1,
  parameter  int D_WIDTH = 16,
  // Bits needed to hold ceil(N/M)-1, M-1 and N-1 respectively.
  localparam int HI_W    = $clog2((N + M - 1) / M),
  localparam int LO_W    = $clog2(M),
  localparam int AW      = (M == 1) ? $clog2(N) : (HI_W + LO_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [D_WIDTH-1:0] din_tdata,
  input  logic               din_tvalid,
  input  logic               din_tlast,
  output logic               din_tready,
  output logic [AW-1:0]      write_addr,
  output logic [D_WIDTH-1:0] write_data,
  output logic               write_en,
  output logic               write_done,
  output logic               frame_err
);

  // Beat counter must reach N-1; hi bank index needs at least one bit to exist.
  localparam int c_CNT_W  = ($clog2(N) < 1) ? 1 : $clog2(N);
  localparam int c_HI_W_S = (HI_W < 1) ? 1 : HI_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECEIVE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_count;
  logic [AW-1:0]        w_cur_addr;
  logic                 w_hs;
  logic                 w_at_last;
  logic                 w_end;
  logic                 w_start;

  logic [AW-1:0]        r_write_addr;
  logic [D_WIDTH-1:0]   r_write_data;
  logic                 r_write_en;
  logic                 r_write_done;
  logic                 r_frame_err;

  assign w_start   = (r_state == S_IDLE) && load;
  assign w_hs      = din_tvalid && (r_state == S_RECEIVE);
  assign w_at_last = (r_count == c_CNT_W'(N - 1));
  // Either the final coefficient or an (early) tlast closes the frame.
  assign w_end     = w_hs && (w_at_last || din_tlast);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; ready is a pure function of the current state.
  always_comb begin
    w_state_nxt = r_state;
    din_tready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_nxt = S_RECEIVE;
        end
      end
      S_RECEIVE: begin
        din_tready = 1'b1;
        if (w_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Wait for load to drop so one assertion yields exactly one frame.
        if (!load) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Beat counter: cleared when a frame is requested, advanced per handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_start) begin
      r_count <= '0;
    end else if (w_hs) begin
      r_count <= r_count + c_CNT_W'(1);
    end
  end

  generate
    if (M == 1) begin : g_linear
      // Single bank: the address is simply the coefficient index.
      assign w_cur_addr = AW'(r_count);
    end else begin : g_banked
      logic [c_HI_W_S-1:0] r_addr_hi;
      logic [LO_W-1:0]     r_addr_lo;

      // Bank index wraps at M-1 and carries into the row index; non power of
      // two M therefore leaves unused addresses between rows.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_addr_hi <= '0;
          r_addr_lo <= '0;
        end else if (w_start) begin
          r_addr_hi <= '0;
          r_addr_lo <= '0;
        end else if (w_hs) begin
          if (r_addr_lo == LO_W'(M - 1)) begin
            r_addr_lo <= '0;
            r_addr_hi <= r_addr_hi + c_HI_W_S'(1);
          end else begin
            r_addr_lo <= r_addr_lo + LO_W'(1);
          end
        end
      end

      // When HI_W is zero the padded hi bit is dropped by the cast.
      assign w_cur_addr = AW'({r_addr_hi, r_addr_lo});
    end
  endgenerate

  // Memory write port and status, registered one cycle behind the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_addr <= '0;
      r_write_data <= '0;
      r_write_en   <= 1'b0;
      r_write_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_write_en   <= w_hs;
      r_write_done <= w_end;
      if (w_hs) begin
        r_write_addr <= w_cur_addr;
        r_write_data <= din_tdata;
      end
      if (w_start) begin
        r_frame_err <= 1'b0;
      end else if (w_end) begin
        // Good frame only when tlast lands exactly on coefficient N-1.
        r_frame_err <= (w_at_last != din_tlast);
      end
    end
  end

  assign write_addr = r_write_addr;
  assign write_data = r_write_data;
  assign write_en   = r_write_en;
  assign write_done = r_write_done;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_in.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_axis_in
//  Brief    : Self-checking bench for axis_in (N=541/M=1 and N=7/M=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_in;

  localparam int N   = 541;
  localparam int M   = 1;
  localparam int AW  = 10;
  localparam int N3  = 7;
  localparam int M3  = 3;
  localparam int AW3 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset      = 1'b1;
  logic              load       = 1'b0;
  logic [15:0]       din_tdata  = '0;
  logic              din_tvalid = 1'b0;
  logic              din_tlast  = 1'b0;
  logic              din_tready;
  logic [AW-1:0]     write_addr;
  logic [15:0]       write_data;
  logic              write_en;
  logic              write_done;
  logic              frame_err;

  logic              load3   = 1'b0;
  logic [15:0]       tdata3  = '0;
  logic              tvalid3 = 1'b0;
  logic              tlast3  = 1'b0;
  logic              tready3;
  logic [AW3-1:0]    waddr3;
  logic [15:0]       wdata3;
  logic              we3;
  logic              wdone3;
  logic              ferr3;

  axis_in #(.N(N), .M(M), .D_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .load(load),
    .din_tdata(din_tdata), .din_tvalid(din_tvalid), .din_tlast(din_tlast),
    .din_tready(din_tready), .write_addr(write_addr), .write_data(write_data),
    .write_en(write_en), .write_done(write_done), .frame_err(frame_err)
  );

  axis_in #(.N(N3), .M(M3), .D_WIDTH(16)) dut3 (
    .clk(clk), .reset(reset), .load(load3),
    .din_tdata(tdata3), .din_tvalid(tvalid3), .din_tlast(tlast3),
    .din_tready(tready3), .write_addr(waddr3), .write_data(wdata3),
    .write_en(we3), .write_done(wdone3), .frame_err(ferr3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Banked address of coefficient i: row i/m, bank i%m, row stride 2^low.
  function automatic int addr_of(input int i, input int m, input int low);
    return (i / m) * (1 << low) + (i % m);
  endfunction

  typedef struct {
    int addr;
    int data;
    bit last;
  } wr_t;

  wr_t  exp_q[$];
  int   wr_count   = 0;
  int   done_count = 0;
  int   last_addr  = 0;
  logic pend_hs    = 1'b0;
  logic pend_rst   = 1'b1;

  // Scoreboard: a write must follow every handshake by one cycle and match
  // the next expected coefficient; done only with the frame's last write.
  always @(negedge clk) begin : cmp
    wr_t e;
    chk("write_en_latency", write_en, pend_hs && !pend_rst);
    if (write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", write_addr, e.addr);
        chk("write_data", write_data, e.data);
        chk("write_done_on_write", write_done, e.last);
      end
      wr_count++;
      last_addr = int'(write_addr);
    end else begin
      chk("write_done_idle", write_done, 0);
    end
    if (write_done === 1'b1) done_count++;
    pend_hs  = (din_tvalid === 1'b1) && (din_tready === 1'b1);
    pend_rst = (reset === 1'b1);
  end

  int   cap_addr[$];
  logic cap_done[$];
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      cap_addr.push_back(int'(waddr3));
      cap_done.push_back(wdone3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero();
    chk("rst_tready", din_tready, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_write_addr", write_addr, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_write_done", write_done, 0);
    chk("rst_frame_err", frame_err, 0);
  endtask

  // Drive one frame of nbeats beats, tlast on beat tlast_idx (-1: none).
  // abort_after >= 0 stops driving after that beat (caller then resets).
  task automatic send_frame(input int nbeats, input int tlast_idx, input int base,
                            input bit gaps, input int abort_after);
    int n_acc;
    int n_push;
    n_acc  = (tlast_idx >= 0 && tlast_idx < N) ? tlast_idx + 1 : N;
    n_push = (abort_after >= 0 && abort_after + 1 < n_acc) ? abort_after + 1 : n_acc;
    for (int i = 0; i < n_push; i++)
      exp_q.push_back('{addr_of(i, M, 0), (i + base) & 16'hFFFF, (i == n_acc - 1)});
    wr_count   = 0;
    done_count = 0;
    load = 1'b1;
    tick();
    chk("frame_err_cleared", frame_err, 0);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        for (int g = 0; g < 4; g++) begin
          if ($urandom_range(0, 1) == 0) break;
          din_tvalid = 1'b0;
          tick();
        end
      end
      din_tvalid = 1'b1;
      din_tdata  = 16'(i + base);
      din_tlast  = (i == tlast_idx);
      @(negedge clk);
      if (i < n_acc) chk("tready_beat", din_tready, 1);
      else           chk("tready_after_end", din_tready, 0);
      tick();
      if (i == abort_after) break;
    end
    din_tvalid = 1'b0;
    din_tlast  = 1'b0;
  endtask

  task automatic end_frame(input int exp_wr, input bit exp_err, input int exp_last);
    tick();
    chk("write_count", wr_count, exp_wr);
    chk("done_count", done_count, 1);
    chk("frame_err", frame_err, exp_err);
    chk("tready_done", din_tready, 0);
    chk("last_addr", last_addr, exp_last);
    chk("queue_drained", exp_q.size(), 0);
    load = 1'b0;
    tick();
    tick();
    chk("tready_idle", din_tready, 0);
  endtask

  initial begin
    int exp3[7];
    exp3 = '{0, 1, 2, 4, 5, 6, 8};

    // Reset state.
    tick();
    tick();
    check_all_zero();
    reset = 1'b0;
    tick();

    // N=7, M=3: banked addresses with a gap at 3 and 7.
    for (int i = 0; i < N3; i++) chk("model_addr_of", addr_of(i, M3, 2), exp3[i]);
    load3 = 1'b1;
    tick();
    for (int i = 0; i < N3; i++) begin
      tvalid3 = 1'b1;
      tdata3  = 16'(i + 100);
      tlast3  = (i == N3 - 1);
      tick();
    end
    tvalid3 = 1'b0;
    tlast3  = 1'b0;
    tick();
    tick();
    chk("m3_write_count", cap_addr.size(), N3);
    for (int i = 0; i < N3 && i < cap_addr.size(); i++) begin
      chk("m3_addr", cap_addr[i], exp3[i]);
      chk("m3_done", cap_done[i], (i == N3 - 1));
    end
    chk("m3_frame_err", ferr3, 0);
    chk("m3_tready_done", tready3, 0);
    load3 = 1'b0;
    tick();

    // Good frame, back to back.
    send_frame(541, 540, 0, 1'b0, -1);
    end_frame(541, 1'b0, 540);

    // Good frame with random valid gaps.
    send_frame(541, 540, 0, 1'b1, -1);
    end_frame(541, 1'b0, 540);

    // Early tlast on beat 99; beat 100 is offered but refused.
    send_frame(101, 99, 16'h1000, 1'b0, -1);
    end_frame(100, 1'b1, 99);

    // Missing tlast, then a good frame clears the error.
    send_frame(541, -1, 16'h2000, 1'b0, -1);
    end_frame(541, 1'b1, 540);
    send_frame(541, 540, 16'h3000, 1'b0, -1);
    end_frame(541, 1'b0, 540);

    // Reset after beat 200 abandons the frame without write_done.
    send_frame(541, 540, 16'h4000, 1'b0, 200);
    reset = 1'b1;
    load  = 1'b0;
    tick();
    reset = 1'b0;
    check_all_zero();
    tick();
    tick();
    chk("abort_queue_drained", exp_q.size(), 0);
    chk("abort_no_done", done_count, 0);
    chk("abort_write_count", wr_count, 201);
    send_frame(541, 540, 16'h5000, 1'b0, -1);
    end_frame(541, 1'b0, 540);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
